// File: rtl/rd_port_sched.sv
// rd_port_sched: round-robin read scheduler; grants one input port and follows its packet sop..eop.
// Define RD_SCHED_TIMEOUT_EN to build the stall watchdog (TIMEOUT_CYC idle cycles per grant).
module rd_port_sched #(
   parameter int IN_PORT_NUM = 16,
   parameter int TIMEOUT_CYC = 256
) (
   input  logic                           i_clk,
   input  logic                           i_rst_n,
   input  logic [IN_PORT_NUM-1:0]         i_req,
   input  logic                           i_mux_sop,
   input  logic                           i_mux_eop,
   input  logic                           i_mux_vld,
   output logic [IN_PORT_NUM-1:0]         o_rd_req,
   output logic                           o_en,
   output logic [$clog2(IN_PORT_NUM)-1:0] o_sel,
   output logic                           o_busy,
   output logic                           o_pkt_done,
   output logic [15:0]                    o_pkt_cnt,
   output logic                           o_timeout
);

   localparam int SEL_W = $clog2(IN_PORT_NUM);

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_WAIT_SOP = 2'd1;
   localparam logic [1:0] ST_XFER     = 2'd2;
   localparam logic [1:0] ST_DONE     = 2'd3;

   logic [1:0]             state_q,  state_d;
   logic [SEL_W-1:0]       ptr_q,    ptr_d;
   logic [SEL_W-1:0]       sel_q,    sel_d;
   logic [SEL_W-1:0]       grant_s;
   logic [IN_PORT_NUM-1:0] rd_req_q, rd_req_d;
   logic                   en_q,     en_d;
   logic                   busy_q,   busy_d;
   logic                   done_q,   done_d;
   logic [15:0]            cnt_q,    cnt_d;
   logic                   tmo_hit_s;

   // Round-robin pick: nearest requester above ptr_q with wrap; smallest offset overrides.
   always_comb begin
      logic [31:0] idx_v;
      idx_v   = 32'd0;
      grant_s = ptr_q;
      for (int i = IN_PORT_NUM; i >= 1; i--) begin
         idx_v   = 32'((int'(ptr_q) + i) % IN_PORT_NUM);
         grant_s = i_req[idx_v[SEL_W-1:0]] ? idx_v[SEL_W-1:0] : grant_s;
      end
   end

   // Next-state decode and next values of every registered output.
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      sel_d    = sel_q;
      en_d     = en_q;
      busy_d   = busy_q;
      rd_req_d = '0;
      done_d   = 1'b0;
      cnt_d    = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (|i_req) begin
               state_d  = ST_WAIT_SOP;
               sel_d    = grant_s;
               en_d     = 1'b1;
               busy_d   = 1'b1;
               rd_req_d = IN_PORT_NUM'(1) << grant_s;
            end else begin
               en_d   = 1'b0;
               busy_d = 1'b0;
            end
         end
         ST_WAIT_SOP: begin
            if (i_mux_vld && i_mux_sop) begin
               state_d = i_mux_eop ? ST_DONE : ST_XFER;
            end else if (tmo_hit_s) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_WAIT_SOP;
            end
         end
         ST_XFER: begin
            if (i_mux_vld && i_mux_eop) begin
               state_d = ST_DONE;
            end else if (tmo_hit_s) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_XFER;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            ptr_d   = sel_q;
         end
         default: begin
            state_d = ST_IDLE;
            en_d    = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
      // Entering DONE: release the grant; only a real eop counts as a completed packet.
      if (state_d == ST_DONE) begin
         en_d   = 1'b0;
         busy_d = 1'b0;
         if (tmo_hit_s) begin
            done_d = 1'b0;
         end else begin
            done_d = 1'b1;
            cnt_d  = cnt_q + 16'd1;
         end
      end else begin
         done_d = 1'b0;
      end
   end

   // State and output registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= ST_IDLE;
         ptr_q    <= SEL_W'(IN_PORT_NUM - 1);
         sel_q    <= '0;
         rd_req_q <= '0;
         en_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         cnt_q    <= 16'd0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         sel_q    <= sel_d;
         rd_req_q <= rd_req_d;
         en_q     <= en_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         cnt_q    <= cnt_d;
      end
   end

`ifdef RD_SCHED_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             timeout_q;

   // Watchdog: counts grant cycles without valid; zero whenever no grant is in flight.
   always_comb begin
      tmo_d     = '0;
      tmo_hit_s = 1'b0;
      if ((state_q == ST_WAIT_SOP) || (state_q == ST_XFER)) begin
         if (i_mux_vld) begin
            tmo_d = '0;
         end else begin
            tmo_d     = tmo_q + TMO_W'(1);
            tmo_hit_s = (tmo_d == TMO_W'(TIMEOUT_CYC));
         end
      end else begin
         tmo_d = '0;
      end
   end

   // Watchdog counter and timeout pulse register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         tmo_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         tmo_q     <= tmo_d;
         timeout_q <= tmo_hit_s;
      end
   end

   assign o_timeout = timeout_q;
`else
   assign tmo_hit_s = 1'b0;
   assign o_timeout = 1'b0;
`endif

   assign o_rd_req   = rd_req_q;
   assign o_en       = en_q;
   assign o_sel      = sel_q;
   assign o_busy     = busy_q;
   assign o_pkt_done = done_q;
   assign o_pkt_cnt  = cnt_q;

endmodule

// File: tb/tb_rd_port_sched.sv
// Bench for rd_port_sched: vector table, hand sequences for multi-cycle corners, random packets vs model.
module tb_rd_port_sched;

   logic        i_clk;
   logic        i_rst_n;
   logic [15:0] i_req;
   logic        i_mux_sop;
   logic        i_mux_eop;
   logic        i_mux_vld;
   logic [15:0] o_rd_req;
   logic        o_en;
   logic [3:0]  o_sel;
   logic        o_busy;
   logic        o_pkt_done;
   logic [15:0] o_pkt_cnt;
   logic        o_timeout;

   int checks = 0;
   int errors = 0;

   // Reference model state: round-robin pointer, completed count, current grant.
   int          m_ptr;
   logic [15:0] m_cnt;
   int          m_sel;

   typedef struct {
      logic [15:0] req;
      int          exp_port;
   } vec_t;

   vec_t vecs[13];

   rd_port_sched #(.IN_PORT_NUM(16), .TIMEOUT_CYC(8)) dut (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_req      (i_req),
      .i_mux_sop  (i_mux_sop),
      .i_mux_eop  (i_mux_eop),
      .i_mux_vld  (i_mux_vld),
      .o_rd_req   (o_rd_req),
      .o_en       (o_en),
      .o_sel      (o_sel),
      .o_busy     (o_busy),
      .o_pkt_done (o_pkt_done),
      .o_pkt_cnt  (o_pkt_cnt),
      .o_timeout  (o_timeout)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Round-robin choice from the rules: first requester at ptr+1, ptr+2, ... modulo 16.
   function automatic int pick(input logic [15:0] req, input int ptr);
      int r;
      r = -1;
      for (int k = 1; k <= 16; k++) begin
         if ((r < 0) && req[(ptr + k) % 16]) r = (ptr + k) % 16;
      end
      return r;
   endfunction

   task automatic chk_hold(input string tag);
      chk({tag, "_en"},      32'(o_en),       32'd1);
      chk({tag, "_busy"},    32'(o_busy),     32'd1);
      chk({tag, "_rdreq"},   32'(o_rd_req),   32'd0);
      chk({tag, "_done"},    32'(o_pkt_done), 32'd0);
      chk({tag, "_timeout"}, 32'(o_timeout),  32'd0);
      chk({tag, "_sel"},     32'(o_sel),      32'(m_sel));
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_en"},    32'(o_en),       32'd0);
      chk({tag, "_busy"},  32'(o_busy),     32'd0);
      chk({tag, "_rdreq"}, 32'(o_rd_req),   32'd0);
      chk({tag, "_done"},  32'(o_pkt_done), 32'd0);
      chk({tag, "_sel"},   32'(o_sel),      32'(m_sel));
      chk({tag, "_cnt"},   32'(o_pkt_cnt),  32'(m_cnt));
   endtask

   task automatic do_reset();
      i_rst_n   = 1'b0;
      i_req     = 16'h0000;
      i_mux_vld = 1'b0;
      i_mux_sop = 1'b0;
      i_mux_eop = 1'b0;
      tick();
      tick();
      m_ptr = 15;
      m_cnt = 16'd0;
      m_sel = 0;
      chk_idle("reset");
      chk("reset_timeout", 32'(o_timeout), 32'd0);
      i_rst_n = 1'b1;
   endtask

   // Called in IDLE: present req for one sampling edge, then check the grant.
   task automatic do_grant(input logic [15:0] req, input int exp);
      logic [15:0] oh;
      oh    = 16'h0001 << exp;
      i_req = req;
      tick();
      m_sel = exp;
      chk("grant_rdreq", 32'(o_rd_req),   32'(oh));
      chk("grant_sel",   32'(o_sel),      32'(exp));
      chk("grant_en",    32'(o_en),       32'd1);
      chk("grant_busy",  32'(o_busy),     32'd1);
      chk("grant_done",  32'(o_pkt_done), 32'd0);
   endtask

   // Called in WAIT_SOP: deliver a packet of 'beats' beats, optionally with ignorable noise.
   task automatic send_pkt(input int beats, input bit noisy);
      if (noisy) begin
         repeat ($urandom_range(0, 2)) begin
            i_mux_vld = 1'($urandom_range(0, 1));
            i_mux_sop = 1'b0;
            i_mux_eop = 1'($urandom_range(0, 1));
            i_req     = 16'($urandom);
            tick();
            chk_hold("wsop_noise");
         end
      end
      for (int b = 0; b < beats; b++) begin
         if (noisy && (b > 0)) begin
            repeat ($urandom_range(0, 2)) begin
               i_mux_vld = 1'b0;
               i_mux_sop = 1'($urandom_range(0, 1));
               i_mux_eop = 1'($urandom_range(0, 1));
               i_req     = 16'($urandom);
               tick();
               chk_hold("xfer_gap");
            end
         end
         i_mux_vld = 1'b1;
         i_mux_sop = (b == 0) ? 1'b1 : (noisy ? 1'($urandom_range(0, 1)) : 1'b0);
         i_mux_eop = (b == beats - 1);
         tick();
         if (b != beats - 1) chk_hold("beat");
      end
      m_cnt = m_cnt + 16'd1;
      m_ptr = m_sel;
      chk("done_pulse", 32'(o_pkt_done), 32'd1);
      chk("done_en",    32'(o_en),       32'd0);
      chk("done_busy",  32'(o_busy),     32'd0);
      chk("done_rdreq", 32'(o_rd_req),   32'd0);
      chk("done_cnt",   32'(o_pkt_cnt),  32'(m_cnt));
      i_mux_vld = 1'b0;
      i_mux_sop = 1'b0;
      i_mux_eop = 1'b0;
      tick();
      chk_idle("post_done");
   endtask

   initial begin
      vecs[0]  = '{16'h0001, 0};
      vecs[1]  = '{16'h0001, 0};
      vecs[2]  = '{16'h8000, 15};
      vecs[3]  = '{16'h0011, 0};
      vecs[4]  = '{16'h0011, 4};
      vecs[5]  = '{16'h0011, 0};
      vecs[6]  = '{16'h0060, 5};
      vecs[7]  = '{16'h0011, 0};
      vecs[8]  = '{16'h0011, 4};
      vecs[9]  = '{16'hFFFF, 5};
      vecs[10] = '{16'h0020, 5};
      vecs[11] = '{16'h8001, 15};
      vecs[12] = '{16'h8001, 0};

      // Single request, 4-beat packet.
      do_reset();
      do_grant(16'h0001, 0);
      send_pkt(4, 1'b0);
      chk("first_cnt", 32'(o_pkt_cnt), 32'd1);

      // All requesting, 1-beat packets: strict rotation and minimum turnaround.
      do_reset();
      for (int k = 0; k < 17; k++) begin
         do_grant(16'hFFFF, k % 16);
         send_pkt(1, 1'b0);
      end
      chk("rotation_cnt", 32'(o_pkt_cnt), 32'd17);

      // Vector table, each entry one 1-beat packet.
      do_reset();
      for (int v = 0; v < 13; v++) begin
         do_grant(vecs[v].req, vecs[v].exp_port);
         send_pkt(1, 1'b0);
      end
      i_req = 16'h0000;
      repeat (3) begin
         tick();
         chk_idle("idle_hold");
      end

      // Reset pulled mid-XFER on port 3.
      do_grant(16'h0008, 3);
      i_req     = 16'h0000;
      i_mux_vld = 1'b1;
      i_mux_sop = 1'b1;
      tick();
      chk_hold("xfer_sop");
      i_mux_sop = 1'b0;
      tick();
      chk_hold("xfer_mid");
      #2;
      i_rst_n = 1'b0;
      #1;
      m_ptr = 15;
      m_cnt = 16'd0;
      m_sel = 0;
      chk_idle("async_rst");
      chk("async_rst_timeout", 32'(o_timeout), 32'd0);
      i_mux_vld = 1'b1;
      i_mux_eop = 1'b1;
      tick();
      chk("rst_no_done", 32'(o_pkt_done), 32'd0);
      chk("rst_cnt",     32'(o_pkt_cnt),  32'd0);
      i_mux_vld = 1'b0;
      i_mux_eop = 1'b0;
      i_rst_n   = 1'b1;
      do_grant(16'h0008, 3);
      send_pkt(2, 1'b0);

      // Stalled grant on port 2 with pointer at 0.
      do_grant(16'h0001, 0);
      send_pkt(1, 1'b0);
      do_grant(16'h0004, 2);
      i_req = 16'h0000;
`ifdef RD_SCHED_TIMEOUT_EN
      for (int c = 1; c < 8; c++) begin
         tick();
         chk_hold("stall");
      end
      tick();
      m_ptr = 2;
      chk("tmo_pulse", 32'(o_timeout),  32'd1);
      chk("tmo_en",    32'(o_en),       32'd0);
      chk("tmo_busy",  32'(o_busy),     32'd0);
      chk("tmo_done",  32'(o_pkt_done), 32'd0);
      chk("tmo_cnt",   32'(o_pkt_cnt),  32'(m_cnt));
      tick();
      chk("tmo_one_cycle", 32'(o_timeout), 32'd0);
      chk_idle("tmo_idle");
`else
      repeat (20) begin
         tick();
         chk_hold("stall");
      end
      send_pkt(1, 1'b0);
`endif
      do_grant(16'h000C, 3);
      send_pkt(1, 1'b0);

      // Random requests and packets against the model.
      for (int it = 0; it < 150; it++) begin
         logic [15:0] req;
         req = 16'($urandom);
         if ($urandom_range(0, 7) == 0) req = 16'h0000;
         if (req == 16'h0000) begin
            i_req = req;
            tick();
            chk_idle("rand_idle");
         end else begin
            do_grant(req, pick(req, m_ptr));
            send_pkt($urandom_range(1, 6), 1'b1);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
